// File: rtl/spu_ins_dispatch_if.sv
// Write, issue-control and decoded-output signals of the SPU instruction dispatch buffer.
// The master drives writes and issue control; the slave is the dispatch buffer.
interface spu_ins_dispatch_if #(
   parameter int N_PIPES = 2,
   parameter int DEPTH   = 8,
   parameter int INS_W   = 57,
   parameter int CW      = $clog2(DEPTH+1)
);
   logic [N_PIPES-1:0]       in_valid;
   logic [N_PIPES*INS_W-1:0] in_ins;
   logic [N_PIPES-1:0]       in_ready;
   logic [N_PIPES-1:0]       stall;
   logic                     lockstep;
   logic                     flush;
   logic [N_PIPES-1:0]       out_valid;
   logic [N_PIPES*11-1:0]    opcode;
   logic [N_PIPES*7-1:0]     ra_addr;
   logic [N_PIPES*7-1:0]     rb_addr;
   logic [N_PIPES*7-1:0]     rc_addr;
   logic [N_PIPES*7-1:0]     rt_addr;
   logic [N_PIPES*18-1:0]    imm18;
   logic [N_PIPES*CW-1:0]    occupancy;

   modport master (
      output in_valid, in_ins, stall, lockstep, flush,
      input  in_ready, out_valid, opcode, ra_addr, rb_addr, rc_addr, rt_addr, imm18, occupancy
   );

   modport slave (
      input  in_valid, in_ins, stall, lockstep, flush,
      output in_ready, out_valid, opcode, ra_addr, rb_addr, rc_addr, rt_addr, imm18, occupancy
   );
endinterface

// File: rtl/spu_ins_dispatch.sv
// Per-pipe instruction FIFOs with lockstep or independent issue into registered decoded outputs.
// Non-issuing pipes present NOP_OPC with zeroed fields.
module spu_ins_dispatch #(
   parameter int          N_PIPES = 2,
   parameter int          DEPTH   = 8,
   parameter int          INS_W   = 57,
   parameter logic [10:0] NOP_OPC = 11'b01000000001,
   parameter int          CW      = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   spu_ins_dispatch_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [INS_W-1:0]      mem_q    [N_PIPES][DEPTH];
   logic [PW-1:0]         rd_ptr_q [N_PIPES];
   logic [PW-1:0]         rd_ptr_d [N_PIPES];
   logic [PW-1:0]         wr_ptr_q [N_PIPES];
   logic [PW-1:0]         wr_ptr_d [N_PIPES];
   logic [INS_W-1:0]      head     [N_PIPES];
   logic [N_PIPES*CW-1:0] occ_q, occ_d;
   logic [N_PIPES-1:0]    vld_q, vld_d;
   logic [N_PIPES*11-1:0] opc_q, opc_d;
   logic [N_PIPES*7-1:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d, rt_q, rt_d;
   logic [N_PIPES*18-1:0] imm_q, imm_d;
   logic [N_PIPES-1:0]    ready, push, elig, issue;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] v);
      return (v == PW'(DEPTH-1)) ? '0 : v + PW'(1);
   endfunction

   always_comb begin
      ready = '0;
      push  = '0;
      elig  = '0;
      issue = '0;
      for (int p = 0; p < N_PIPES; p++) begin
         head[p]  = mem_q[p][rd_ptr_q[p]];
         ready[p] = (occ_q[p*CW +: CW] < CW'(DEPTH)) && !bus.flush;
         push[p]  = bus.in_valid[p] && ready[p];
         elig[p]  = (occ_q[p*CW +: CW] != '0) && !bus.stall[p];
      end
      // Lockstep: any empty or stalled pipe blocks every pipe
      for (int p = 0; p < N_PIPES; p++)
         issue[p] = !bus.flush && (bus.lockstep ? &elig : elig[p]);
   end

   always_comb begin
      occ_d = occ_q;
      vld_d = issue;
      opc_d = '0;
      ra_d  = '0;
      rb_d  = '0;
      rc_d  = '0;
      rt_d  = '0;
      imm_d = '0;
      for (int p = 0; p < N_PIPES; p++) begin
         rd_ptr_d[p] = issue[p] ? ptr_inc(rd_ptr_q[p]) : rd_ptr_q[p];
         wr_ptr_d[p] = push[p]  ? ptr_inc(wr_ptr_q[p]) : wr_ptr_q[p];
         occ_d[p*CW +: CW] = occ_q[p*CW +: CW] + CW'(push[p]) - CW'(issue[p]);
         opc_d[p*11 +: 11] = NOP_OPC;
         if (issue[p]) begin
            opc_d[p*11 +: 11] = head[p][56:46];
            imm_d[p*18 +: 18] = head[p][45:28];
            ra_d[p*7 +: 7]    = head[p][27:21];
            rb_d[p*7 +: 7]    = head[p][20:14];
            rc_d[p*7 +: 7]    = head[p][13:7];
            rt_d[p*7 +: 7]    = head[p][6:0];
         end
         if (bus.flush) begin
            rd_ptr_d[p] = '0;
            wr_ptr_d[p] = '0;
            occ_d[p*CW +: CW] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < N_PIPES; p++) begin
            rd_ptr_q[p] <= '0;
            wr_ptr_q[p] <= '0;
         end
         occ_q <= '0;
         vld_q <= '0;
         opc_q <= {N_PIPES{NOP_OPC}};
         ra_q  <= '0;
         rb_q  <= '0;
         rc_q  <= '0;
         rt_q  <= '0;
         imm_q <= '0;
      end else begin
         for (int p = 0; p < N_PIPES; p++) begin
            rd_ptr_q[p] <= rd_ptr_d[p];
            wr_ptr_q[p] <= wr_ptr_d[p];
         end
         occ_q <= occ_d;
         vld_q <= vld_d;
         opc_q <= opc_d;
         ra_q  <= ra_d;
         rb_q  <= rb_d;
         rc_q  <= rc_d;
         rt_q  <= rt_d;
         imm_q <= imm_d;
      end
   end

   // Storage needs no reset: occupancy alone decides which entries are live
   always_ff @(posedge clk) begin
      for (int p = 0; p < N_PIPES; p++)
         if (push[p]) mem_q[p][wr_ptr_q[p]] <= bus.in_ins[p*INS_W +: INS_W];
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = vld_q;
   assign bus.opcode    = opc_q;
   assign bus.ra_addr   = ra_q;
   assign bus.rb_addr   = rb_q;
   assign bus.rc_addr   = rc_q;
   assign bus.rt_addr   = rt_q;
   assign bus.imm18     = imm_q;
   assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_spu_ins_dispatch.sv
// Randomised and directed bench for spu_ins_dispatch: a queue-based reference model feeds
// per-pipe expectation queues that a negedge monitor drains against the DUT outputs.
module tb_spu_ins_dispatch;
   localparam int          NP    = 2;
   localparam int          DEPTH = 8;
   localparam int          INS_W = 57;
   localparam int          CW    = $clog2(DEPTH+1);
   localparam logic [10:0] NOP   = 11'h201;

   typedef struct {
      logic        v;
      logic [56:0] w;
      int          occ;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   logic [56:0] mq  [NP][$];
   exp_t        exq [NP][$];

   spu_ins_dispatch_if #(.N_PIPES(NP), .DEPTH(DEPTH), .INS_W(INS_W)) bus ();

   spu_ins_dispatch #(.N_PIPES(NP), .DEPTH(DEPTH), .INS_W(INS_W), .NOP_OPC(NOP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int p, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s pipe%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, p, got, exp, $time);
      end
   endtask

   // Reference model: one queue of words per pipe, advanced once per rising edge
   always @(posedge clk) begin
      logic [NP-1:0] el;
      logic          all_el, iss, pu;
      logic [56:0]   w;
      exp_t          e;
      if (!rst_n) begin
         for (int p = 0; p < NP; p++) begin
            mq[p].delete();
            e = '{1'b0, '0, 0};
            exq[p].push_back(e);
         end
      end else begin
         for (int p = 0; p < NP; p++) el[p] = (mq[p].size() != 0) && !bus.stall[p];
         all_el = &el;
         for (int p = 0; p < NP; p++) begin
            iss = !bus.flush && (bus.lockstep ? all_el : el[p]);
            pu  = !bus.flush && bus.in_valid[p] && (mq[p].size() < DEPTH);
            w   = '0;
            if (iss) w = mq[p].pop_front();
            if (pu) mq[p].push_back(bus.in_ins[p*INS_W +: INS_W]);
            if (bus.flush) mq[p].delete();
            e = '{iss, w, mq[p].size()};
            exq[p].push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      for (int p = 0; p < NP; p++) begin
         if (exq[p].size() != 0) begin
            e = exq[p].pop_front();
            check("out_valid", p, 32'(bus.out_valid[p]), 32'(e.v));
            check("opcode", p, 32'(bus.opcode[p*11 +: 11]), e.v ? 32'(e.w[56:46]) : 32'(NOP));
            check("imm18", p, 32'(bus.imm18[p*18 +: 18]), e.v ? 32'(e.w[45:28]) : 32'd0);
            check("ra", p, 32'(bus.ra_addr[p*7 +: 7]), e.v ? 32'(e.w[27:21]) : 32'd0);
            check("rb", p, 32'(bus.rb_addr[p*7 +: 7]), e.v ? 32'(e.w[20:14]) : 32'd0);
            check("rc", p, 32'(bus.rc_addr[p*7 +: 7]), e.v ? 32'(e.w[13:7]) : 32'd0);
            check("rt", p, 32'(bus.rt_addr[p*7 +: 7]), e.v ? 32'(e.w[6:0]) : 32'd0);
            check("occupancy", p, 32'(bus.occupancy[p*CW +: CW]), 32'(e.occ));
            check("in_ready", p, 32'(bus.in_ready[p]),
                  32'((mq[p].size() < DEPTH) && !bus.flush));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   function automatic logic [56:0] rnd_word();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[56:0];
   endfunction

   task automatic drive(input int p, input logic v, input logic [56:0] w);
      bus.in_valid[p] = v;
      bus.in_ins[p*INS_W +: INS_W] = w;
   endtask

   task automatic idle(input int n);
      bus.in_valid = '0;
      repeat (n) tick();
   endtask

   function automatic logic [31:0] occ_of(input int p);
      return 32'(bus.occupancy[p*CW +: CW]);
   endfunction

   initial begin
      logic [56:0] w0, w1, first_w1;
      bus.in_valid = '0;
      bus.in_ins   = '0;
      bus.stall    = '0;
      bus.lockstep = 1'b0;
      bus.flush    = 1'b0;
      first_w1     = '0;

      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      for (int p = 0; p < NP; p++) begin
         check("rst_occ", p, occ_of(p), 32'd0);
         check("rst_opcode", p, 32'(bus.opcode[p*11 +: 11]), 32'h201);
      end
      check("rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 0, 32'(bus.in_ready), 32'd3);

      // Independent back-to-back stream on both pipes
      for (int i = 0; i < 5; i++) begin
         w0 = rnd_word();
         w1 = rnd_word();
         w1[45:28] = w0[45:28] ^ 18'h2a5;
         if (i == 0) first_w1 = w1;
         drive(0, 1'b1, w0);
         drive(1, 1'b1, w1);
         tick();
         if (i == 0) check("first_latency", 0, 32'(bus.out_valid), 32'd0);
         if (i == 1) begin
            check("stream_valid", 0, 32'(bus.out_valid), 32'd3);
            check("pipe1_own_imm", 1, 32'(bus.imm18[35:18]), 32'(first_w1[45:28]));
         end
      end
      idle(4);

      // Fill pipe 0 past full while stalled, then drain across the pointer wrap
      bus.stall = 2'b01;
      for (int i = 0; i < 10; i++) begin
         drive(0, 1'b1, rnd_word());
         tick();
         if (i == 6) check("ready_before_full", 0, 32'(bus.in_ready[0]), 32'd1);
      end
      drive(0, 1'b0, '0);
      check("full_occ", 0, occ_of(0), 32'd8);
      check("full_in_ready", 0, 32'(bus.in_ready[0]), 32'd0);
      bus.stall = 2'b00;
      idle(10);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1, rnd_word());
         tick();
      end
      idle(4);

      // Lockstep: pipe 1 empty blocks pipe 0 until it gets a word
      bus.lockstep = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b1, rnd_word());
         tick();
      end
      idle(2);
      check("lock_blocked", 0, 32'(bus.out_valid), 32'd0);
      check("lock_occ_before", 0, occ_of(0), 32'd3);
      drive(1, 1'b1, rnd_word());
      tick();
      drive(1, 1'b0, '0);
      tick();
      check("lock_joint", 0, 32'(bus.out_valid), 32'd3);
      check("lock_occ_after", 0, occ_of(0), 32'd2);
      tick();
      check("lock_single", 0, 32'(bus.out_valid), 32'd0);
      bus.lockstep = 1'b0;
      idle(4);

      // Simultaneous push and pop hold occupancy at 4
      bus.stall = 2'b01;
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1, rnd_word());
         tick();
      end
      bus.stall = 2'b00;
      for (int i = 0; i < 6; i++) begin
         drive(0, 1'b1, rnd_word());
         tick();
         check("pushpop_occ", 0, occ_of(0), 32'd4);
      end
      idle(6);

      // Flush with writes pending
      bus.stall = 2'b11;
      for (int i = 0; i < 5; i++) begin
         drive(0, 1'b1, rnd_word());
         drive(1, 1'b1, rnd_word());
         tick();
      end
      check("pre_flush_occ", 0, occ_of(0), 32'd5);
      bus.stall = 2'b00;
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      bus.in_valid = '0;
      check("flush_occ0", 0, occ_of(0), 32'd0);
      check("flush_occ1", 1, occ_of(1), 32'd0);
      check("flush_nop", 0, 32'(bus.out_valid), 32'd0);
      idle(3);

      // Random traffic
      repeat (400) begin
         for (int p = 0; p < NP; p++) drive(p, 1'($urandom_range(0, 1)), rnd_word());
         bus.stall    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         bus.lockstep = ($urandom_range(0, 3) == 0);
         bus.flush    = ($urandom_range(0, 40) == 0);
         tick();
      end
      bus.flush    = 1'b0;
      bus.stall    = '0;
      bus.lockstep = 1'b0;
      idle(10);

      // Asynchronous reset in the middle of a stream
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b1, rnd_word());
         drive(1, 1'b1, rnd_word());
         tick();
      end
      check("pre_reset_valid", 0, 32'(bus.out_valid), 32'd3);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_valid", 0, 32'(bus.out_valid), 32'd0);
      for (int p = 0; p < NP; p++) begin
         check("async_opcode", p, 32'(bus.opcode[p*11 +: 11]), 32'(NOP));
         check("async_occ", p, occ_of(p), 32'd0);
      end
      bus.in_valid = '0;
      repeat (2) tick();
      rst_n = 1'b1;
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/spu_ins_dispatch.md
# spu_ins_dispatch

Parametrised instruction dispatch buffer for the SPU execution pipes. It accepts packed 57-bit instruction words per pipe through a valid/ready write port, buffers them in one FIFO per pipe, and issues one decoded instruction per pipe per cycle. Issue can be lockstep across all pipes or independent per pipe, with per-pipe stall and a global flush. It sits between the instruction source and `spu_pipes_top`, and replaces direct per-cycle driving of opcode, register-address and immediate inputs.

## Interface
- `N_PIPES`, default 2: number of pipes. Pipe 0 is even, pipe 1 is odd.
- `DEPTH`, default 8: FIFO entries per pipe, at least 2. Need not be a power of two.
- `INS_W`, default 57: packed instruction width. Fixed field map below.
- `NOP_OPC`, default 11'b01000000001: opcode driven on a pipe that does not issue.
- `CW`, default $clog2(DEPTH+1): occupancy width.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in N_PIPES: per-pipe write request.
- `in_ins` in N_PIPES*INS_W: packed words. Pipe p occupies bits [p*INS_W +: INS_W].
- `in_ready` out N_PIPES: per-pipe write accept, combinational.
- `stall` in N_PIPES: per-pipe issue hold.
- `lockstep` in 1: 1 selects all-or-none issue; 0 selects independent issue. Sampled every cycle.
- `flush` in 1: synchronous clear of all FIFOs.
- `out_valid` out N_PIPES: registered; pipe issued this cycle.
- `opcode` out N_PIPES*11: registered opcode per pipe.
- `ra_addr`, `rb_addr`, `rc_addr`, `rt_addr` out N_PIPES*7 each: registered register addresses.
- `imm18` out N_PIPES*18: registered immediate. I16/I10/I8/I7 are its low 16/10/8/7 bits and are taken downstream.
- `occupancy` out N_PIPES*CW: registered entry count per pipe.

## Operation
- Field map per word:
  - opcode [56:46]
  - imm18 [45:28]
  - ra [27:21]
  - rb [20:14]
  - rc [13:7]
  - rt [6:0]
- Each pipe decodes its immediate from its own word; there is no cross-pipe field sharing.
- Write: `in_ready[p] = (occupancy[p] < DEPTH) && !flush`. An entry is pushed when `in_valid[p] && in_ready[p]`.
- No write-to-issue bypass. A full FIFO rejects writes even if it issues in the same cycle.
- Issue eligibility per pipe: `elig[p] = (occupancy[p] != 0) && !stall[p]`.
- Issue in lockstep mode: `issue[p] = AND over all elig`. Any empty or stalled pipe blocks every pipe.
- Issue in independent mode: `issue[p] = elig[p]`.
- On issue, the FIFO head pops. Output registers load the decoded head and set `out_valid[p]` to 1.
- Without issue, the output registers load `opcode = NOP_OPC`, all address and immediate fields 0, and `out_valid = 0`.
- Occupancy update: next = occupancy + push − pop. Push and pop in the same cycle leave occupancy unchanged.
- Read and write pointers wrap from DEPTH−1 to 0.
- Flush: all pointers and occupancies go to 0. Writes in the flush cycle are dropped. The next output is NOP on all pipes.
- Flush has priority over issue and write.
- FIFO order is strict per pipe; no reordering.

## Timing
- Reset, asynchronous on `rst_n` low:
  - occupancy 0 and pointers 0
  - `out_valid` 0
  - `opcode` NOP_OPC
  - addresses and `imm18` 0
- `in_ready` is all 1 once `rst_n` is high and `flush` is low.
- Latency: a word written at edge T is eligible at edge T+1. With no stall it appears on the outputs after edge T+1.
- Throughput: one issue per pipe per cycle when the FIFO stays non-empty.
- A `stall` change takes effect at the next edge; outputs after that edge are NOP for the stalled pipe.
- A `lockstep` change takes effect on the same edge's issue decision.
- Reset asserted mid-stream discards all buffered words immediately, without waiting for a clock edge.

## Test plan
- **Reset:** hold `rst_n` low, then release. Require all occupancy 0, opcode = 0x201 on both pipes, `out_valid` 0, `in_ready` 2'b11.
- **Independent stream:** write 5 words per pipe, back to back, with pipe 1 `imm18` distinct from pipe 0. Require 5 consecutive `out_valid` per pipe, starting one edge after each first write, fields matching the field map. Require pipe 1 `imm18` to equal pipe 1's own bits [45:28].
- **Full/wrap:** with DEPTH=8, stall pipe 0 and write 10 words. Require `in_ready[0]` to drop after 8 accepts, occupancy 8. Release stall and require 8 issues in order. Write 4 more and require correct order across the pointer wrap.
- **Lockstep:** `lockstep`=1, pipe 0 holds 3 words, pipe 1 empty. Require no issue on either pipe. Write 1 word to pipe 1, then require exactly one joint issue, after which pipe 0 occupancy is 2.
- **Simultaneous push/pop:** at occupancy 4, write and issue every cycle for 6 cycles. Require occupancy to stay at 4 and the output order to match the write order.
- **Flush and async reset:** with occupancy 5, assert `flush` with `in_valid` high. Require occupancy 0 next edge, the write dropped, NOP outputs. Separately, assert `rst_n` low between edges and require outputs to reset before the next edge.
